// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared geometry defaults, sync polarity constants, colour-bar table
// and segment-length helper for the VGA display core.
// No ports; imported by vga_display_core.
package vga_timing_pkg;

  // 640x480@75 default geometry
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 64;
  localparam int DEF_H_BP     = 120;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 16;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // Colour bars as {r,g,b}, index 0 is the leftmost bar:
  // white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][2:0] BAR_TABLE = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  function automatic int seg_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: fixed-depth register delay line with synchronous reset to RST_VAL.
// Latency DEPTH cycles; DEPTH = 0 degenerates to a wire. No backpressure.
// Ports: clk, reset (sync, active-high), din[WIDTH], dout[WIDTH].
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = clk ^ reset;
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_display_core.sv
// vga_display_core: VGA timing generator + frame counter + renderer latency compensation.
// Latency: coordinate to pins RENDER_LAT+1 cycles. No backpressure: free-running pixel stream.
// Ports: px_clk, reset (sync, active-high); x_px/y_px/active_req renderer request;
//   frame_cnt/frame_tick; pix_in renderer colour; hsync/vsync/activevideo/rrggbb to pins.
// Optional: VGA_TEST_PATTERN_EN adds test_en, which replaces pix_in with 8 vertical colour bars.
module vga_display_core
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit SYNC_POL   = SYNC_ACTIVE_LOW,
  parameter int COORD_W    = 10,
  parameter int COLOR_W    = 6,
  parameter int RENDER_LAT = 2,
  parameter int FRAME_W    = 16
) (
  input  logic               px_clk,
  input  logic               reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               test_en,
`endif
  output logic [COORD_W-1:0] x_px,
  output logic [COORD_W-1:0] y_px,
  output logic               active_req,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               frame_tick,
  input  logic [COLOR_W-1:0] pix_in,
  output logic               hsync,
  output logic               vsync,
  output logic               activevideo,
  output logic [COLOR_W-1:0] rrggbb
);

  localparam int H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_seg
    $error("vga_display_core: porch and sync widths must be non-zero");
  end
  if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_coord
    $error("vga_display_core: COORD_W too narrow for the line/frame totals");
  end
  if (RENDER_LAT < 0 || RENDER_LAT > 15) begin : g_bad_lat
    $error("vga_display_core: RENDER_LAT must be 0..15");
  end

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  // Pin level when a sync is not asserted.
  localparam bit SYNC_IDLE = (SYNC_POL == SYNC_ACTIVE_HIGH) ? SYNC_ACTIVE_LOW : SYNC_ACTIVE_HIGH;

  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic               hs_raw, vs_raw;
  logic [2:0]         ctl_dly;   // {hs, vs, active} after the renderer-latency delay
  logic [COLOR_W-1:0] pix_sel;

  // Timing counters and frame counter
  always_ff @(posedge px_clk) begin
    if (reset) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + COORD_W'(1);
      end else begin
        h_cnt <= h_cnt + COORD_W'(1);
      end
      if (frame_tick) frame_cnt <= frame_cnt + FRAME_W'(1);
    end
  end

  assign x_px       = h_cnt;
  assign y_px       = v_cnt;
  assign active_req = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign frame_tick = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign hs_raw     = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_raw     = (v_cnt >= VS_START) && (v_cnt < VS_END);

  // Syncs travel as active-high "asserted" flags; polarity is applied at the pins.
  vga_delay_line #(
    .WIDTH  (3),
    .DEPTH  (RENDER_LAT),
    .RST_VAL(3'b000)
  ) u_ctl_dly (
    .clk  (px_clk),
    .reset(reset),
    .din  ({hs_raw, vs_raw, active_req}),
    .dout (ctl_dly)
  );

`ifdef VGA_TEST_PATTERN_EN
  logic [COORD_W-1:0] x_dly;
  logic [2:0]         bar;
  logic [COLOR_W-1:0] bar_color;

  vga_delay_line #(
    .WIDTH  (COORD_W),
    .DEPTH  (RENDER_LAT),
    .RST_VAL('0)
  ) u_x_dly (
    .clk  (px_clk),
    .reset(reset),
    .din  (h_cnt),
    .dout (x_dly)
  );

  // Each colour bit takes the R, G or B bit of the bar entry, split MSB-first
  // into three equal groups across the colour bus.
  always_comb begin
    bar_color = '0;
    bar       = 3'((32'(x_dly) * 32'd8) / 32'(H_ACTIVE));
    for (int i = 0; i < COLOR_W; i++) begin
      bar_color[i] = BAR_TABLE[bar][(i * 3) / COLOR_W];
    end
  end

  assign pix_sel = test_en ? bar_color : pix_in;
`else
  assign pix_sel = pix_in;
`endif

  // Output register: aligns pix_in with the delayed syncs and blanks outside the visible area.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      hsync       <= SYNC_IDLE;
      vsync       <= SYNC_IDLE;
      activevideo <= 1'b0;
      rrggbb      <= '0;
    end else begin
      hsync       <= ctl_dly[2] ? SYNC_POL : SYNC_IDLE;
      vsync       <= ctl_dly[1] ? SYNC_POL : SYNC_IDLE;
      activevideo <= ctl_dly[0];
      rrggbb      <= ctl_dly[0] ? pix_sel : '0;
    end
  end

endmodule

// File: tb/tb_vga_display_core.sv
module tb_vga_display_core;

  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 25
  localparam int VT = VA + VF + VS + VB;   // 11
  localparam int FR = HT * VT;             // 275
  localparam int CW = 5, PW = 6, FW = 2;
  localparam int L1 = 2, L2 = 0;
  localparam int MAXC = 2048;
  localparam int NV = 10;

  logic px_clk = 1'b0;
  logic reset  = 1'b1;
  logic [PW-1:0] pix1, pix2;
  logic [CW-1:0] x1, y1, x2, y2;
  logic [FW-1:0] fc1, fc2;
  logic ar1, ar2, ft1, ft2, hs1, hs2, vs1, vs2, av1, av2;
  logic [PW-1:0] rgb1, rgb2;
`ifdef VGA_TEST_PATTERN_EN
  logic te = 1'b0;
`endif

  always #5 px_clk = ~px_clk;

  vga_display_core #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .COORD_W(CW), .COLOR_W(PW), .RENDER_LAT(L1), .FRAME_W(FW)
  ) dut1 (
    .px_clk(px_clk), .reset(reset),
`ifdef VGA_TEST_PATTERN_EN
    .test_en(te),
`endif
    .x_px(x1), .y_px(y1), .active_req(ar1), .frame_cnt(fc1), .frame_tick(ft1),
    .pix_in(pix1), .hsync(hs1), .vsync(vs1), .activevideo(av1), .rrggbb(rgb1)
  );

  vga_display_core #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1), .COORD_W(CW), .COLOR_W(PW), .RENDER_LAT(L2), .FRAME_W(FW)
  ) dut2 (
    .px_clk(px_clk), .reset(reset),
`ifdef VGA_TEST_PATTERN_EN
    .test_en(te),
`endif
    .x_px(x2), .y_px(y2), .active_req(ar2), .frame_cnt(fc2), .frame_tick(ft2),
    .pix_in(pix2), .hsync(hs2), .vsync(vs2), .activevideo(av2), .rrggbb(rgb2)
  );

  typedef struct {
    int cyc; int x; int y; int tick; int fc; int hs;
  } vec_t;
  vec_t tab [NV];

  int total = 0;
  int bad   = 0;
  int c     = 0;
  logic [PW-1:0] h1 [MAXC];
  logic [PW-1:0] h2 [MAXC];
  bit            teh [MAXC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, c, act, exp);
    end
  endtask

  // Reference: the n-th pixel clock since reset release scans raster position n mod FR.
  function automatic int cx(input int n); return (n % FR) % HT; endfunction
  function automatic int cy(input int n); return (n % FR) / HT; endfunction

  function automatic logic [PW-1:0] bar_col(input int x);
    case ((x * 8) / HA)
      0: return 6'h3F;
      1: return 6'h3C;
      2: return 6'h0F;
      3: return 6'h0C;
      4: return 6'h33;
      5: return 6'h30;
      6: return 6'h03;
      default: return 6'h00;
    endcase
  endfunction

  // Renderer stand-in: value returned for the coordinate requested at cycle idx.
  function automatic logic [PW-1:0] pick(input int seg, input int idx);
    int mode;
    mode = (seg == 0) ? ((c < 300) ? 1 : (c < 600) ? 2 : 0) : 0;
    if (mode == 1) return 6'h3F;
    if (mode == 2) return (idx < 0) ? 6'd0 : PW'(cx(idx));
    return PW'($urandom);
  endfunction

  task automatic chk_pins(input string tag, input int lat, input bit pol,
                          input logic hs, input logic vs, input logic av,
                          input logic [PW-1:0] rgb, input logic [PW-1:0] prev_pix);
    bit ea, eh, ev;
    logic [PW-1:0] er;
    int n, x, y;
    if (c < lat + 1) begin
      ea = 0; eh = 0; ev = 0; er = '0;
    end else begin
      n  = c - lat - 1;
      x  = cx(n);
      y  = cy(n);
      ea = (x < HA) && (y < VA);
      eh = (x >= HA + HF) && (x < HA + HF + HS);
      ev = (y >= VA + VF) && (y < VA + VF + VS);
      er = !ea ? 6'd0 : (teh[c-1] ? bar_col(x) : prev_pix);
    end
    chk({tag, "_hsync"}, hs, eh ? pol : !pol);
    chk({tag, "_vsync"}, vs, ev ? pol : !pol);
    chk({tag, "_active"}, av, ea);
    chk({tag, "_rgb"}, rgb, er);
  endtask

  task automatic run_cycle(input int seg);
    h1[c] = pick(seg, c - L1);
    h2[c] = pick(seg, c - L2);
    pix1 = h1[c];
    pix2 = h2[c];
`ifdef VGA_TEST_PATTERN_EN
    te = (seg == 1) && (c >= 60) && (c < 160);
    teh[c] = te;
`else
    teh[c] = 1'b0;
`endif
    @(negedge px_clk);
    chk("x1", x1, cx(c));
    chk("y1", y1, cy(c));
    chk("x2", x2, cx(c));
    chk("y2", y2, cy(c));
    chk("req1", ar1, (cx(c) < HA) && (cy(c) < VA));
    chk("req2", ar2, (cx(c) < HA) && (cy(c) < VA));
    chk("tick1", ft1, (c % FR) == FR - 1);
    chk("tick2", ft2, (c % FR) == FR - 1);
    chk("fcnt1", fc1, (c / FR) % (1 << FW));
    chk("fcnt2", fc2, (c / FR) % (1 << FW));
    chk_pins("p1", L1, 1'b0, hs1, vs1, av1, rgb1, (c > 0) ? h1[c-1] : 6'd0);
    chk_pins("p2", L2, 1'b1, hs2, vs2, av2, rgb2, (c > 0) ? h2[c-1] : 6'd0);
    if (seg == 0) begin
      for (int k = 0; k < NV; k++) begin
        if (tab[k].cyc == c) begin
          chk("vec_x", x1, tab[k].x);
          chk("vec_y", y1, tab[k].y);
          chk("vec_tick", ft1, tab[k].tick);
          chk("vec_fcnt", fc1, tab[k].fc);
          chk("vec_hsync", hs1, tab[k].hs);
        end
      end
    end
    @(posedge px_clk);
    #1;
    c++;
  endtask

  initial begin
    // {cycle after release, x, y, frame_tick, frame_cnt, hsync of the RENDER_LAT=2 instance}
    tab = '{
      '{0,    0,  0,  0, 0, 1},
      '{20,   20, 0,  0, 0, 1},
      '{21,   21, 0,  0, 0, 0},
      '{23,   23, 0,  0, 0, 0},
      '{24,   24, 0,  0, 0, 1},
      '{25,   0,  1,  0, 0, 1},
      '{274,  24, 10, 1, 0, 1},
      '{275,  0,  0,  0, 1, 1},
      '{1099, 24, 10, 1, 3, 1},
      '{1100, 0,  0,  0, 0, 1}
    };
    pix1 = '0;
    pix2 = '0;
    reset = 1'b1;
    repeat (3) @(posedge px_clk);
    #1;
    reset = 1'b0;
    c = 0;
    while (c < 1185) run_cycle(0);

    // Mid-frame reset for a single edge, then restart from (0,0) with a flushed pipeline.
    chk("pre_rst_x", x1, 10);
    chk("pre_rst_y", y1, 3);
    reset = 1'b1;
    @(posedge px_clk);
    #1;
    reset = 1'b0;
    c = 0;
    chk("post_rst_x", x1, 0);
    chk("post_rst_y", y1, 0);
    chk("post_rst_hsync", hs1, 1);
    chk("post_rst_av", av1, 0);
    chk("post_rst_fcnt", fc1, 0);
    while (c < 400) run_cycle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
